rtib_core: RTL and testbench
============================

Name: rtib_core

Overview:
Real-time input buffer: the input-side counterpart of the RTIO output buffer core. It watches a synchronous DATA_LEN-bit input bus and detects selected rising/falling edges or an explicit capture strobe. Each event is stamped with the 64-bit RTIO counter and queued in a FIFO as a 128-bit word for the CPU/AXI side to drain. Single clock domain; sits between input pads (already synchronised) and the RTIO readback path.

Parameters:
DEPTH, 1024, FIFO word capacity (power of two).
ADDR_LEN, 10, log2(DEPTH).
THRESHOLD, 1000, prog_full assertion level (words stored).
DATA_LEN, 8, input bus width (1..64).

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO, stage and error state
capture_en  input  1  enables event generation (auto_start equivalent)
rise_mask  input  DATA_LEN  per-bit rising-edge enable
fall_mask  input  DATA_LEN  per-bit falling-edge enable
capture_strobe  input  1  forces an event this cycle
data_in  input  DATA_LEN  monitored bus, synchronous to clk
counter  input  64  RTIO timestamp counter
rd_en  input  1  pop request
rti_out  output  128  popped word {timestamp[63:0], (64-DATA_LEN) zeros, data[DATA_LEN-1:0]}
rti_valid  output  1  rti_out valid pulse
empty  output  1  FIFO empty
full  output  1  count == DEPTH
prog_full  output  1  count >= THRESHOLD
overflow_error  output  1  one-cycle pulse: event dropped
overflow_error_data  output  128  last dropped word
underflow_error  output  1  one-cycle pulse: rd_en while empty
overflow_count  output  16  saturating count of dropped events

Behaviour:
- Reset (resetn low, async): all outputs 0 except empty=1; pointers, count, stage, prev register cleared.
- prev <= data_in every cycle, regardless of capture_en or flush (so enabling never produces a spurious edge).
- Cycle N detection: event = capture_en && (capture_strobe || |((data_in & ~prev & rise_mask) | (~data_in & prev & fall_mask))). Coincident sources yield exactly one event.
- Stage: on event, at end of N: st_valid<=1, st_word<={counter, 0, data_in} (counter sampled in cycle N). st_valid is cleared otherwise.
- Write in N+1: accepted if st_valid && (count<DEPTH || read accepted same cycle). The word is in memory at end of N+1; empty falls in N+2. Back-to-back events sustain 1 word/cycle.
- Drop: st_valid && not accepted -> overflow_error=1 in N+2, overflow_error_data<=st_word, overflow_count+1 saturating at 16'hFFFF.
- Read: rd_en && !empty in cycle M pops head. rti_out is registered and rti_valid=1 in M+1. rti_out holds its value until the next pop. rd_en && empty -> underflow_error pulse in M+1, no pointer change.
- Simultaneous read+write: count unchanged. At full, both are accepted. At empty, the read is rejected and the write is accepted.
- Pointers are ADDR_LEN bits and wrap modulo DEPTH. count is ADDR_LEN+1 bits.
- full/prog_full/empty are registered from next-state count, so they are exact in the cycle after the update.
- flush (sync, priority over everything except resetn): count, pointers, st_valid, errors, overflow_count cleared. empty=1 the next cycle. An event detected in the flush cycle is discarded. rti_out is cleared.
- capture_en low: no events; the stage still drains normally.

Decomposition:
- Package rtio_pkg holds: RTIO_WORD_W=128, TS_W=64, the function that packs {ts, pad, data} into a word, and typedef rtio_word_t.
- Sub-module rtib_sync_fifo (single-clock, DEPTH x 128, registered 1-cycle read, count/full/empty/prog_full) is used by rtib_core.
- Edge detection, stage and error logic stay in rtib_core.

Test Plan:
- rise_mask=8'h01, data_in 0->1 while counter=100 -> one word 128'h0000000000000064_0000000000000001 readable; empty low exactly 2 cycles after the edge.
- capture_strobe together with rising edge on bit 3 (rise_mask=8'h08), counter=7 -> exactly one word; timestamp 7, data 8'h08.
- DEPTH=16: 17 consecutive events, no reads -> full=1 after 16; overflow_error pulse for word 17 with overflow_error_data = its packed word; overflow_count=1. Then event+rd_en in same cycle at full -> accepted, count stays 16.
- 48 events with interleaved random rd_en on DEPTH=16 -> pointers wrap; readout order and timestamps match the scoreboard; underflow_error only when popping while empty.
- capture_en=0 while toggling data_in -> no writes. Assert capture_en with data_in stable -> no event. Next toggle -> one event.
- Assert flush with 5 words queued and an event in the same cycle -> empty=1, count 0, nothing read. Drop resetn asynchronously mid-burst -> outputs go to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/rtio_pkg.sv
// rtio_pkg: shared RTIO word layout and timestamp/data packing helper
package rtio_pkg;
  localparam int RTIO_WORD_W = 128;
  localparam int TS_W = 64;
  localparam int PAD_W = RTIO_WORD_W - TS_W;
  typedef logic [RTIO_WORD_W-1:0] rtio_word_t;
  function automatic rtio_word_t pack_word(input logic [TS_W-1:0] ts, input logic [PAD_W-1:0] data);
    return {ts, data};
  endfunction
endpackage

// File: rtl/rtib_sync_fifo.sv
// rtib_sync_fifo: single-clock word FIFO with registered read and occupancy flags
module rtib_sync_fifo
  import rtio_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int ADDR_LEN = 10,
  parameter int THRESHOLD = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  input  logic       wr_en,
  input  rtio_word_t wr_data,
  output logic       wr_ack,
  input  logic       rd_en,
  output rtio_word_t rd_data,
  output logic       rd_valid,
  output logic       underflow,
  output logic       empty,
  output logic       full,
  output logic       prog_full
);
  localparam int CW = ADDR_LEN + 1;
  localparam logic [ADDR_LEN:0] FULL_C = CW'(DEPTH);
  rtio_word_t mem_q [DEPTH];
  rtio_word_t rd_data_q;
  logic [ADDR_LEN-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_LEN:0] count_q, count_d;
  logic rd_ok, rd_valid_q, underflow_q, empty_q, full_q, prog_full_q;
  // a pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read
  always_comb begin
    rd_ok = rd_en && !flush && count_q != '0;
    wr_ack = wr_en && !flush && (count_q != FULL_C || rd_ok);
    count_d = flush ? '0 : count_q + CW'(wr_ack) - CW'(rd_ok);
  end
  always_ff @(posedge clk) if (wr_ack) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      prog_full_q <= 1'b0;
    end else begin
      wr_ptr_q <= flush ? '0 : wr_ptr_q + ADDR_LEN'(wr_ack);
      rd_ptr_q <= flush ? '0 : rd_ptr_q + ADDR_LEN'(rd_ok);
      count_q <= count_d;
      rd_data_q <= flush ? '0 : rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_q <= rd_ok;
      underflow_q <= rd_en && !flush && count_q == '0;
      empty_q <= count_d == '0;
      full_q <= count_d == FULL_C;
      prog_full_q <= int'(count_d) >= THRESHOLD;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign underflow = underflow_q;
  assign empty = empty_q;
  assign full = full_q;
  assign prog_full = prog_full_q;
endmodule

// File: rtl/rtib_core.sv
// rtib_core: edge/strobe triggered timestamp capture queued into a drainable FIFO
module rtib_core
  import rtio_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int ADDR_LEN = 10,
  parameter int THRESHOLD = 1000,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                capture_en,
  input  logic [DATA_LEN-1:0] rise_mask,
  input  logic [DATA_LEN-1:0] fall_mask,
  input  logic                capture_strobe,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [TS_W-1:0]     counter,
  input  logic                rd_en,
  output rtio_word_t          rti_out,
  output logic                rti_valid,
  output logic                empty,
  output logic                full,
  output logic                prog_full,
  output logic                overflow_error,
  output rtio_word_t          overflow_error_data,
  output logic                underflow_error,
  output logic [15:0]         overflow_count
);
  logic [DATA_LEN-1:0] prev_q;
  logic ev, st_valid_q, st_valid_d, wr_ack, drop, ovf_q;
  rtio_word_t st_word_q, st_word_d, ovf_data_q;
  logic [15:0] ovf_cnt_q;
  // prev tracks the bus unconditionally so enabling capture never sees a stale edge
  always_comb begin
    ev = capture_en && (capture_strobe ||
         |((data_in & ~prev_q & rise_mask) | (~data_in & prev_q & fall_mask)));
    st_valid_d = ev && !flush;
    st_word_d = ev ? pack_word(counter, PAD_W'(data_in)) : st_word_q;
    drop = st_valid_q && !wr_ack && !flush;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= '0;
      st_valid_q <= 1'b0;
      st_word_q <= '0;
      ovf_q <= 1'b0;
      ovf_data_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      prev_q <= data_in;
      st_valid_q <= st_valid_d;
      st_word_q <= st_word_d;
      ovf_q <= drop;
      ovf_data_q <= flush ? '0 : drop ? st_word_q : ovf_data_q;
      ovf_cnt_q <= flush ? '0 : ovf_cnt_q + 16'(drop && ovf_cnt_q != 16'hFFFF);
    end
  end
  rtib_sync_fifo #(
    .DEPTH(DEPTH),
    .ADDR_LEN(ADDR_LEN),
    .THRESHOLD(THRESHOLD)
  ) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .wr_en(st_valid_q),
    .wr_data(st_word_q),
    .wr_ack(wr_ack),
    .rd_en(rd_en),
    .rd_data(rti_out),
    .rd_valid(rti_valid),
    .underflow(underflow_error),
    .empty(empty),
    .full(full),
    .prog_full(prog_full)
  );
  assign overflow_error = ovf_q;
  assign overflow_error_data = ovf_data_q;
  assign overflow_count = ovf_cnt_q;
endmodule

// File: tb/tb_rtib_core.sv
// tb_rtib_core: directed self-checking bench for rtib_core with a 16-deep FIFO
module tb_rtib_core;
  logic clk = 0, resetn = 0, flush = 0, capture_en = 0, capture_strobe = 0, rd_en = 0;
  logic [7:0] rise_mask = 0, fall_mask = 0, data_in = 0;
  logic [63:0] counter = 0;
  logic [127:0] rti_out, overflow_error_data;
  logic rti_valid, empty, full, prog_full, overflow_error, underflow_error;
  logic [15:0] overflow_count;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  rtib_core #(.DEPTH(16), .ADDR_LEN(4), .THRESHOLD(12), .DATA_LEN(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .capture_en(capture_en),
    .rise_mask(rise_mask), .fall_mask(fall_mask), .capture_strobe(capture_strobe),
    .data_in(data_in), .counter(counter), .rd_en(rd_en), .rti_out(rti_out),
    .rti_valid(rti_valid), .empty(empty), .full(full), .prog_full(prog_full),
    .overflow_error(overflow_error), .overflow_error_data(overflow_error_data),
    .underflow_error(underflow_error), .overflow_count(overflow_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_chk++; if ({rti_valid, full, prog_full, overflow_error, underflow_error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000", {rti_valid, full, prog_full, overflow_error, underflow_error}); end
    n_chk++; if (rti_out !== 128'h0) begin n_fail++; $display("FAIL reset_rti_out got=%h exp=0", rti_out); end
    n_chk++; if (overflow_error_data !== 128'h0 || overflow_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_ovf got=%h/%h exp=0/0", overflow_error_data, overflow_count); end
    resetn = 1;
    tick();
  endtask

  task automatic test_rise();
    logic [127:0] w;
    capture_en = 1; rise_mask = 8'h01; fall_mask = 0; data_in = 0;
    tick();
    data_in = 8'h01; counter = 64'd100;
    tick();
    counter = 64'd101;
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rise_empty_n1 got=%b exp=1", empty); end
    tick();
    n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL rise_empty_n2 got=%b exp=0", empty); end
    rd_en = 1;
    tick();
    rd_en = 0;
    w = rti_out;
    n_chk++; if (rti_valid !== 1'b1) begin n_fail++; $display("FAIL rise_valid got=%b exp=1", rti_valid); end
    n_chk++; if (rti_out !== 128'h0000000000000064_0000000000000001) begin
      n_fail++; $display("FAIL rise_word got=%h exp=%h", rti_out, 128'h0000000000000064_0000000000000001); end
    tick();
    n_chk++; if (rti_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL rise_after got=valid%b/empty%b exp=valid0/empty1", rti_valid, empty); end
    n_chk++; if (rti_out !== 128'h0000000000000064_0000000000000001) begin
      n_fail++; $display("FAIL rise_hold got=%h exp=%h", rti_out, w); end
  endtask

  task automatic test_coincident();
    rise_mask = 8'h08; data_in = 0;
    tick();
    data_in = 8'h08; capture_strobe = 1; counter = 64'd7;
    tick();
    capture_strobe = 0; counter = 64'd8;
    tick();
    tick();
    rd_en = 1;
    tick();
    n_chk++; if (rti_valid !== 1'b1 || rti_out !== {64'd7, 64'h08}) begin
      n_fail++; $display("FAIL coinc_word got=%b/%h exp=1/%h", rti_valid, rti_out, {64'd7, 64'h08}); end
    tick();
    rd_en = 0;
    n_chk++; if (rti_valid !== 1'b0 || underflow_error !== 1'b1) begin
      n_fail++; $display("FAIL coinc_single got=valid%b/underflow%b exp=valid0/underflow1", rti_valid, underflow_error); end
    tick();
    n_chk++; if (underflow_error !== 1'b0) begin n_fail++; $display("FAIL coinc_uf_pulse got=%b exp=0", underflow_error); end
  endtask

  task automatic test_enable();
    capture_en = 0; rise_mask = 8'hFF; fall_mask = 8'hFF; data_in = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(i * 37 + 1);
      tick();
    end
    data_in = 8'h5A;
    tick();
    tick();
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL en_off got=empty%b exp=1", empty); end
    capture_en = 1;
    tick(); tick(); tick();
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL en_stable got=empty%b exp=1", empty); end
    data_in = 8'h5B; counter = 64'd33;
    tick();
    counter = 64'd34;
    tick();
    tick();
    n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL en_toggle got=empty%b exp=0", empty); end
    rd_en = 1;
    tick();
    rd_en = 0;
    n_chk++; if (rti_out !== {64'd33, 64'h5B}) begin n_fail++; $display("FAIL en_word got=%h exp=%h", rti_out, {64'd33, 64'h5B}); end
    tick();
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL en_one_event got=empty%b exp=1", empty); end
    rise_mask = 0; fall_mask = 0;
  endtask

  task automatic test_overflow();
    logic [127:0] exp;
    capture_en = 1;
    for (int i = 0; i < 17; i++) begin
      capture_strobe = 1; data_in = 8'(i); counter = 64'(200 + i);
      tick();
    end
    capture_strobe = 0;
    n_chk++; if (full !== 1'b1 || prog_full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full got=full%b/prog%b exp=1/1", full, prog_full); end
    n_chk++; if (overflow_error !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", overflow_error); end
    tick();
    n_chk++; if (overflow_error !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b exp=1", overflow_error); end
    n_chk++; if (overflow_error_data !== {64'd216, 64'd16}) begin
      n_fail++; $display("FAIL ovf_data got=%h exp=%h", overflow_error_data, {64'd216, 64'd16}); end
    n_chk++; if (overflow_count !== 16'd1) begin n_fail++; $display("FAIL ovf_count got=%0d exp=1", overflow_count); end
    tick();
    n_chk++; if (overflow_error !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end got=%b exp=0", overflow_error); end
    capture_strobe = 1; data_in = 8'hAA; counter = 64'd500;
    tick();
    capture_strobe = 0; rd_en = 1;
    tick();
    rd_en = 0;
    n_chk++; if (rti_valid !== 1'b1 || rti_out !== {64'd200, 64'd0}) begin
      n_fail++; $display("FAIL full_rw_read got=%b/%h exp=1/%h", rti_valid, rti_out, {64'd200, 64'd0}); end
    n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_rw_count got=full%b exp=1", full); end
    tick();
    n_chk++; if (overflow_error !== 1'b0 || overflow_count !== 16'd1) begin
      n_fail++; $display("FAIL full_rw_nodrop got=%b/%0d exp=0/1", overflow_error, overflow_count); end
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1;
      tick();
      exp = (i < 16) ? {64'(200 + i), 64'(i)} : {64'd500, 64'hAA};
      n_chk++; if (rti_valid !== 1'b1 || rti_out !== exp) begin
        n_fail++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, rti_valid, rti_out, exp); end
    end
    rd_en = 0;
    n_chk++; if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty got=empty%b/full%b exp=1/0", empty, full); end
  endtask

  task automatic test_wrap();
    logic [127:0] q[$];
    logic [127:0] exp, pend_w;
    int evs, cyc, sz0, pushes, seen;
    bit pend, ev, rd, rd_ok, wr_ok;
    evs = 0; cyc = 0; pushes = 0; seen = 0; pend = 0; pend_w = '0; exp = '0;
    capture_en = 1;
    while (cyc < 300 && (evs < 48 || pend || q.size() > 0)) begin
      ev = evs < 48 && $urandom_range(0, 3) != 0;
      rd = evs >= 48 || $urandom_range(0, 1) == 1;
      capture_strobe = ev; data_in = 8'(cyc); counter = 64'(1000 + cyc); rd_en = rd;
      sz0 = q.size();
      rd_ok = rd && sz0 > 0;
      wr_ok = pend && (sz0 < 16 || rd_ok);
      if (rd_ok) exp = q.pop_front();
      if (wr_ok) begin q.push_back(pend_w); pushes++; end
      pend = ev;
      pend_w = {64'(1000 + cyc), 56'b0, 8'(cyc)};
      if (ev) evs++;
      tick();
      if (rti_valid) seen++;
      n_chk++; if (rti_valid !== rd_ok) begin n_fail++; $display("FAIL wrap_valid_c%0d got=%b exp=%b", cyc, rti_valid, rd_ok); end
      if (rd_ok) begin
        n_chk++; if (rti_out !== exp) begin n_fail++; $display("FAIL wrap_word_c%0d got=%h exp=%h", cyc, rti_out, exp); end
      end
      n_chk++; if (underflow_error !== (rd && sz0 == 0)) begin
        n_fail++; $display("FAIL wrap_uf_c%0d got=%b exp=%b", cyc, underflow_error, rd && sz0 == 0); end
      cyc++;
    end
    capture_strobe = 0; rd_en = 0;
    n_chk++; if (seen !== pushes || q.size() != 0) begin
      n_fail++; $display("FAIL wrap_total got=%0d exp=%0d (model left %0d)", seen, pushes, q.size()); end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    capture_strobe = 1;
    for (int i = 0; i < 5; i++) begin
      counter = 64'(2000 + i); data_in = 8'(i);
      tick();
    end
    capture_strobe = 0;
    tick();
    tick();
    n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL flush_pre got=empty%b exp=0", empty); end
    capture_strobe = 1; flush = 1;
    tick();
    capture_strobe = 0; flush = 0;
    n_chk++; if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty got=empty%b/full%b exp=1/0", empty, full); end
    n_chk++; if (rti_out !== 128'h0) begin n_fail++; $display("FAIL flush_rti_out got=%h exp=0", rti_out); end
    n_chk++; if (overflow_count !== 16'd0 || overflow_error_data !== 128'h0) begin
      n_fail++; $display("FAIL flush_ovf got=%0d/%h exp=0/0", overflow_count, overflow_error_data); end
    tick();
    tick();
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_event_discard got=empty%b exp=1", empty); end
    rd_en = 1;
    tick();
    rd_en = 0;
    n_chk++; if (underflow_error !== 1'b1 || rti_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_read got=uf%b/valid%b exp=1/0", underflow_error, rti_valid); end
  endtask

  task automatic test_async_reset();
    capture_strobe = 1;
    for (int i = 0; i < 4; i++) begin
      counter = 64'(3000 + i); data_in = 8'(i + 1);
      tick();
    end
    rd_en = 1;
    tick();
    rd_en = 0;
    n_chk++; if (rti_valid !== 1'b1 || rti_out !== {64'd3000, 64'd1}) begin
      n_fail++; $display("FAIL arst_pre got=%b/%h exp=1/%h", rti_valid, rti_out, {64'd3000, 64'd1}); end
    #2;
    resetn = 0;
    #1;
    n_chk++; if (rti_valid !== 1'b0 || rti_out !== 128'h0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL arst_immediate got=valid%b/out%h/empty%b exp=0/0/1", rti_valid, rti_out, empty); end
    capture_strobe = 0;
    resetn = 1;
    tick();
    tick();
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_after got=empty%b exp=1", empty); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rise();
    test_coincident();
    test_enable();
    test_overflow();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
